// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR trap sequencer.
// Holds CSR addresses, cause codes, MSTATUS bit indices, load-enable bits and the FSM state type.
package csr_pkg;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [31:0] CauseBreakpoint = 32'd3;
    localparam logic [31:0] CauseEcallM     = 32'd11;
    localparam logic [31:0] CauseIrqExt     = 32'h8000_000B;
    localparam logic [31:0] CauseIrqTimer   = 32'h8000_0007;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;

    localparam int unsigned LdMstatus = 0;
    localparam int unsigned LdMtvec   = 1;
    localparam int unsigned LdMepc    = 2;
    localparam int unsigned LdMcause  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StSaveEpc,
        StSaveCause,
        StUpdStatus,
        StJump,
        StRetStatus,
        StRetJump
    } state_e;

    typedef enum logic {
        ModeTrap,
        ModeRet
    } mode_e;

    // Unmapped addresses decode to no load enable.
    function automatic logic [3:0] csr_addr_decode(logic [11:0] addr);
        logic [3:0] ld;
        ld = '0;
        case (addr)
            CsrMstatus: ld[LdMstatus] = 1'b1;
            CsrMtvec:   ld[LdMtvec]   = 1'b1;
            CsrMepc:    ld[LdMepc]    = 1'b1;
            CsrMcause:  ld[LdMcause]  = 1'b1;
            default:    ld = '0;
        endcase
        return ld;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Software CSR write port from the EX stage: request, address, data and grant.
interface csr_trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            sw_csr_we;
    logic [11:0]     sw_csr_addr;
    logic [XLEN-1:0] sw_csr_wdata;
    logic            sw_csr_ready;

    modport master (
        output sw_csr_we,
        output sw_csr_addr,
        output sw_csr_wdata,
        input  sw_csr_ready
    );

    modport slave (
        input  sw_csr_we,
        input  sw_csr_addr,
        input  sw_csr_wdata,
        output sw_csr_ready
    );
endinterface

// File: rtl/csr_trap_prio.sv
// Priority encoder for trap sources: ebreak > ecall > external irq > timer irq.
// Interrupts are qualified by MSTATUS.MIE.
module csr_trap_prio
    import csr_pkg::*;
(
    input  logic        ebreak_i,
    input  logic        ecall_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        mie_i,
    output logic        trap_req_o,
    output logic [31:0] cause_o
);

    always_comb begin
        trap_req_o = 1'b1;
        cause_o    = '0;
        if (ebreak_i) begin
            cause_o = CauseBreakpoint;
        end else if (ecall_i) begin
            cause_o = CauseEcallM;
        end else if (irq_ext_i && mie_i) begin
            cause_o = CauseIrqExt;
        end else if (irq_timer_i && mie_i) begin
            cause_o = CauseIrqTimer;
        end else begin
            trap_req_o = 1'b0;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/MRET sequencer and software write arbiter for the M-mode CSR bank.
// Optional VECTORED_TRAP_EN enables vectored interrupt targets when mtvec mode is 01.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ebreak,
    input  logic            ecall,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            mret,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] mstatus_q,
    input  logic [XLEN-1:0] mtvec_q,
    input  logic [XLEN-1:0] mepc_q,
    csr_trap_ctrl_if.slave  sw,
    output logic [3:0]      csr_load,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            busy
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    mode_e           mode_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] epc_q;
    logic [31:0]     cause_q;
    logic            stall_q, flush_q, redirect_q, busy_q;
    logic [3:0]      fsm_load_q;

    logic            trap_req;
    logic [31:0]     cause;
    logic            sw_ready;
    logic [XLEN-1:0] status_trap, status_ret, jump_target;

    csr_trap_prio u_prio (
        .ebreak_i    (ebreak),
        .ecall_i     (ecall),
        .irq_ext_i   (irq_ext),
        .irq_timer_i (irq_timer),
        .mie_i       (mstatus_q[MstatusMie]),
        .trap_req_o  (trap_req),
        .cause_o     (cause)
    );

    assign sw_ready        = (state_q == StIdle) && !trap_req && !mret;
    assign sw.sw_csr_ready = sw_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (trap_req || mret) state_d = StDrain;
            StDrain: begin
                if (cnt_q == CntLast) begin
                    state_d = (mode_q == ModeTrap) ? StSaveEpc : StRetStatus;
                end
            end
            StSaveEpc:   state_d = StSaveCause;
            StSaveCause: state_d = StUpdStatus;
            StUpdStatus: state_d = StJump;
            StJump:      state_d = StIdle;
            StRetStatus: state_d = StRetJump;
            StRetJump:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Control outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= ModeTrap;
            cnt_q      <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
            stall_q    <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            fsm_load_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                cnt_q <= '0;
                if (trap_req) begin
                    epc_q   <= trap_pc;
                    cause_q <= cause;
                    mode_q  <= ModeTrap;
                end else if (mret) begin
                    mode_q <= ModeRet;
                end
            end else if (state_q == StDrain) begin
                cnt_q <= cnt_q + 1'b1;
            end
            stall_q    <= (state_d != StIdle);
            busy_q     <= (state_d != StIdle);
            flush_q    <= state_d inside {StDrain, StJump, StRetJump};
            redirect_q <= state_d inside {StJump, StRetJump};
            unique case (state_d)
                StSaveEpc:               fsm_load_q <= 4'(1 << LdMepc);
                StSaveCause:             fsm_load_q <= 4'(1 << LdMcause);
                StUpdStatus, StRetStatus: fsm_load_q <= 4'(1 << LdMstatus);
                default:                 fsm_load_q <= '0;
            endcase
        end
    end

    always_comb begin
        status_trap              = mstatus_q;
        status_trap[MstatusMpie] = mstatus_q[MstatusMie];
        status_trap[MstatusMie]  = 1'b0;
        status_ret               = mstatus_q;
        status_ret[MstatusMie]   = mstatus_q[MstatusMpie];
        status_ret[MstatusMpie]  = 1'b1;
    end

`ifdef VECTORED_TRAP_EN
    always_comb begin
        jump_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && cause_q[31]) begin
            jump_target = jump_target + XLEN'({cause_q[4:0], 2'b00});
        end
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_q[1:0];
    assign jump_target       = {mtvec_q[XLEN-1:2], 2'b00};
`endif

    always_comb begin
        csr_load  = fsm_load_q;
        csr_wdata = '0;
        pc_target = '0;
        unique case (state_q)
            StSaveEpc:   csr_wdata = epc_q;
            StSaveCause: csr_wdata = XLEN'(cause_q);
            StUpdStatus: csr_wdata = status_trap;
            StRetStatus: csr_wdata = status_ret;
            StJump:      pc_target = jump_target;
            StRetJump:   pc_target = mepc_q;
            default: begin
                if (sw.sw_csr_we && sw_ready) begin
                    csr_load  = csr_addr_decode(sw.sw_csr_addr);
                    csr_wdata = sw.sw_csr_wdata;
                end
            end
        endcase
    end

    assign stall       = stall_q;
    assign flush       = flush_q;
    assign pc_redirect = redirect_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: IDLE vector table plus scoreboarded trap/MRET sequences.
module tb_csr_trap_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ebreak, ecall, irq_ext, irq_timer, mret;
    logic [31:0] trap_pc, mstatus_q, mtvec_q, mepc_q;
    logic [3:0]  csr_load;
    logic [31:0] csr_wdata, pc_target;
    logic        stall, flush, pc_redirect, busy;

    csr_trap_ctrl_if #(.XLEN(XLEN)) sw_if ();

    csr_trap_ctrl #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ebreak      (ebreak),
        .ecall       (ecall),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .mret        (mret),
        .trap_pc     (trap_pc),
        .mstatus_q   (mstatus_q),
        .mtvec_q     (mtvec_q),
        .mepc_q      (mepc_q),
        .sw          (sw_if),
        .csr_load    (csr_load),
        .csr_wdata   (csr_wdata),
        .stall       (stall),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic [3:0]  load;
        logic [31:0] wdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] target;
        logic        busy;
    } exp_t;

    typedef struct {
        string       name;
        logic        irq_ext;
        logic        irq_timer;
        logic [31:0] mstatus;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [3:0]  exp_load;
        logic [31:0] exp_wdata;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(logic r, logic [3:0] l, logic [31:0] w, logic s, logic f,
                                logic rd, logic [31:0] t, logic b);
        exp_t e;
        e.ready = r; e.load = l; e.wdata = w; e.stall = s;
        e.flush = f; e.redir = rd; e.target = t; e.busy = b;
        return e;
    endfunction

    function automatic logic [31:0] st_trap(logic [31:0] m);
        logic [31:0] r;
        r = m; r[7] = m[3]; r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] st_ret(logic [31:0] m);
        logic [31:0] r;
        r = m; r[3] = m[7]; r[7] = 1'b1;
        return r;
    endfunction

    task automatic check_pop(input string name);
        exp_t e, a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry in scoreboard", name);
            return;
        end
        e = exp_q.pop_front();
        a = mk(sw_if.sw_csr_ready, csr_load, csr_wdata, stall, flush, pc_redirect, pc_target, busy);
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got rdy=%0b ld=%b wd=%h st=%0b fl=%0b rd=%0b tg=%h bz=%0b, expected rdy=%0b ld=%b wd=%h st=%0b fl=%0b rd=%0b tg=%h bz=%0b",
                     name, a.ready, a.load, a.wdata, a.stall, a.flush, a.redir, a.target, a.busy,
                     e.ready, e.load, e.wdata, e.stall, e.flush, e.redir, e.target, e.busy);
        end
    endtask

    task automatic clear_events();
        ebreak = 0; ecall = 0; irq_ext = 0; irq_timer = 0; mret = 0;
    endtask

    task automatic push_drain();
        for (int i = 0; i < FLUSH; i++) exp_q.push_back(mk(0, 4'b0000, 0, 1, 1, 0, 0, 1));
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] mst, input logic [31:0] tgt);
        exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
        push_drain();
        exp_q.push_back(mk(0, 4'b0100, epc, 1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 4'b1000, cause, 1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 4'b0001, st_trap(mst), 1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 4'b0000, 0, 1, 1, 1, tgt, 1));
        exp_q.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0));
    endtask

    // Stimulus for cycle 0 is already applied; later cycles hold inputs, events drop on the last.
    task automatic run_seq(input string name, input bit clear_last);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (clear_last && i == n - 1) clear_events();
            end
            @(negedge clk);
            check_pop($sformatf("%s[%0d]", name, i));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] vec_tgt;

        vecs[0] = '{"timer_mie0",   0, 1, 32'h0,  0, 12'h305, 32'h0,        1, 4'b0000, 32'h0};
        vecs[1] = '{"sw_mstatus",   1, 0, 32'h80, 1, 12'h300, 32'h11,       1, 4'b0001, 32'h11};
        vecs[2] = '{"sw_mtvec",     0, 0, 32'h0,  1, 12'h305, 32'h22,       1, 4'b0010, 32'h22};
        vecs[3] = '{"sw_mepc",      0, 0, 32'h0,  1, 12'h341, 32'h33,       1, 4'b0100, 32'h33};
        vecs[4] = '{"sw_mcause",    0, 0, 32'h0,  1, 12'h342, 32'h44,       1, 4'b1000, 32'h44};
        vecs[5] = '{"sw_unmapped",  0, 0, 32'h0,  1, 12'h7C0, 32'h55,       1, 4'b0000, 32'h55};
        vecs[6] = '{"sw_we_low",    0, 0, 32'h0,  0, 12'h342, 32'h66,       1, 4'b0000, 32'h0};
        vecs[7] = '{"irqs_mie0",    1, 1, 32'h77, 0, 12'h0,   32'h0,        1, 4'b0000, 32'h0};

        rst = 1;
        clear_events();
        trap_pc = 0; mstatus_q = 0; mtvec_q = 0; mepc_q = 0;
        sw_if.sw_csr_we = 0; sw_if.sw_csr_addr = 0; sw_if.sw_csr_wdata = 0;
        #3;
        exp_q.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0));
        check_pop("reset");
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            irq_ext = vecs[i].irq_ext; irq_timer = vecs[i].irq_timer; mstatus_q = vecs[i].mstatus;
            sw_if.sw_csr_we = vecs[i].we; sw_if.sw_csr_addr = vecs[i].addr;
            sw_if.sw_csr_wdata = vecs[i].wdata;
            exp_q.push_back(mk(vecs[i].exp_ready, vecs[i].exp_load, vecs[i].exp_wdata,
                               0, 0, 0, 0, 0));
            @(negedge clk);
            check_pop(vecs[i].name);
        end
        @(posedge clk); #1;
        clear_events();
        sw_if.sw_csr_we = 0;

        // External interrupt trap
        @(posedge clk); #1;
        mstatus_q = 32'h8; irq_ext = 1; trap_pc = 32'h100; mtvec_q = 32'h400;
        push_trap(32'h100, 32'h8000_000B, 32'h8, 32'h400);
        run_seq("trap_irq_ext", 1);

        // ecall beats a simultaneous timer interrupt
        @(posedge clk); #1;
        mstatus_q = 32'h8; ecall = 1; irq_timer = 1; trap_pc = 32'h200; mtvec_q = 32'h401;
        push_trap(32'h200, 32'd11, 32'h8, 32'h400);
        run_seq("trap_ecall", 1);

        // ebreak wins over a simultaneous mret
        @(posedge clk); #1;
        mstatus_q = 32'h8; ebreak = 1; mret = 1; trap_pc = 32'h50; mtvec_q = 32'h400;
        push_trap(32'h50, 32'd3, 32'h8, 32'h400);
        run_seq("trap_vs_mret", 1);

        // MRET with a software write held pending until IDLE returns
        @(posedge clk); #1;
        mstatus_q = 32'h80; mepc_q = 32'h104; mret = 1;
        sw_if.sw_csr_we = 1; sw_if.sw_csr_addr = 12'h305; sw_if.sw_csr_wdata = 32'hABCD_0000;
        exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
        push_drain();
        exp_q.push_back(mk(0, 4'b0001, st_ret(32'h80), 1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 4'b0000, 0, 1, 1, 1, 32'h104, 1));
        exp_q.push_back(mk(1, 4'b0010, 32'hABCD_0000, 0, 0, 0, 0, 0));
        run_seq("mret_sw", 1);
        @(posedge clk); #1;
        sw_if.sw_csr_we = 0;

        // Timer interrupt with mtvec in vectored mode
`ifdef VECTORED_TRAP_EN
        vec_tgt = 32'h41C;
`else
        vec_tgt = 32'h400;
`endif
        @(posedge clk); #1;
        mstatus_q = 32'h8; irq_timer = 1; trap_pc = 32'h180; mtvec_q = 32'h401;
        push_trap(32'h180, 32'h8000_0007, 32'h8, vec_tgt);
        run_seq("trap_timer_vec", 1);

        // Asynchronous reset in SAVE_CAUSE
        @(posedge clk); #1;
        mstatus_q = 32'h0; ecall = 1; trap_pc = 32'h300; mtvec_q = 32'h800;
        exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
        push_drain();
        exp_q.push_back(mk(0, 4'b0100, 32'h300, 1, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 4'b1000, 32'd11, 1, 0, 0, 0, 1));
        run_seq("rst_mid", 0);
        #1 rst = 1;
        #1;
        exp_q.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
        check_pop("rst_async");
        clear_events();
        #1;
        exp_q.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0));
        check_pop("rst_held_idle");
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        exp_q.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0));
        check_pop("rst_release_idle");
        @(negedge clk);
        exp_q.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0));
        check_pop("rst_stays_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Sequencer and write arbiter for the machine-mode CSR register bank (MSTATUS, MTVEC, MEPC, MCAUSE). Each CSR is a 32-bit load-enabled register that resets to 32'hffffffff. On a trap or MRET it stalls and flushes the pipeline, then drives the CSR load enables in a fixed order and redirects the PC. Outside those sequences it grants software CSR writes from the EX stage to the same register bank.

Parameters:
XLEN, 32, data/address width
FLUSH_CYCLES, 2, cycles flush is held before any CSR update (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ebreak  in  1  EBREAK at commit point (level, held while stalled)
ecall  in  1  ECALL at commit point (level, held while stalled)
irq_ext  in  1  external interrupt, level
irq_timer  in  1  timer interrupt, level
mret  in  1  MRET at commit point
trap_pc  in  XLEN  PC of the instruction at the commit point
mstatus_q  in  XLEN  current MSTATUS register output
mtvec_q  in  XLEN  current MTVEC register output
mepc_q  in  XLEN  current MEPC register output
sw_csr_we  in  1  software CSR write request
sw_csr_addr  in  12  CSR address
sw_csr_wdata  in  XLEN  software write data
sw_csr_ready  out  1  software write granted this cycle
csr_load  out  4  one-hot load enables: [0] MSTATUS, [1] MTVEC, [2] MEPC, [3] MCAUSE
csr_wdata  out  XLEN  data to the selected CSR
stall  out  1  freeze the pipeline
flush  out  1  squash IF/ID/EX
pc_redirect  out  1  one-cycle PC override strobe
pc_target  out  XLEN  redirect target
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, drain counter=0, epc_r=0, cause_r=0. All outputs are 0 except sw_csr_ready, which follows the IDLE rule below.
- States: IDLE, DRAIN, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, JUMP, RET_STATUS, RET_JUMP.
- IDLE trap request is evaluated in priority order:
  - ebreak: cause 3
  - ecall: cause 11
  - irq_ext & mstatus_q[3]: cause 32'h8000000B
  - irq_timer & mstatus_q[3]: cause 32'h80000007
- On a trap request: latch epc_r=trap_pc and cause_r, set mode=TRAP, go to DRAIN.
- Otherwise, on mret: set mode=RET, go to DRAIN.
- A trap and mret in the same cycle: trap wins, mret is ignored.
- Event inputs are ignored outside IDLE. Interrupts are re-sampled only in IDLE.
- DRAIN: stall=flush=1 for exactly FLUSH_CYCLES cycles, then go to SAVE_EPC (TRAP) or RET_STATUS (RET).
- SAVE_EPC: csr_load=0100, csr_wdata=epc_r.
- SAVE_CAUSE: csr_load=1000, csr_wdata=cause_r.
- UPD_STATUS: csr_load=0001, csr_wdata=mstatus_q with bit7 (MPIE)=mstatus_q[3] and bit3 (MIE)=0.
- JUMP: pc_redirect=1, pc_target={mtvec_q[31:2],2'b00}, flush=1, then IDLE.
- RET_STATUS: csr_load=0001, csr_wdata=mstatus_q with bit3=mstatus_q[7] and bit7=1.
- RET_JUMP: pc_redirect=1, pc_target=mepc_q, flush=1, then IDLE.
- stall=1 in every non-IDLE state. busy is equivalent to state!=IDLE.
- Latency: detect at cycle T. Trap redirect occurs at T+FLUSH_CYCLES+4; MRET redirect at T+FLUSH_CYCLES+2. IDLE is re-entered the following cycle.
- Software arbitration: sw_csr_ready=1 only in IDLE with no trap request and no mret that cycle.
- When sw_csr_we&sw_csr_ready, csr_load decodes combinationally from sw_csr_addr: 0x300 MSTATUS, 0x305 MTVEC, 0x341 MEPC, 0x342 MCAUSE. csr_wdata=sw_csr_wdata.
- Software writes to an unmapped address are granted and dropped (csr_load=0).
- csr_load is never multi-hot. It is 0 whenever no state or grant selects a CSR.
- Reset mid-sequence: immediate return to IDLE. Partially written CSRs are not rolled back.

Optional Feature:
VECTORED_TRAP_EN:
- Defined: in JUMP, if mtvec_q[1:0]==2'b01 and cause_r[31]=1, pc_target={mtvec_q[31:2],2'b00}+(cause_r[4:0]<<2).
- Undefined: direct mode always, mtvec_q[1:0] ignored.

Decomposition:
- Package csr_pkg: CSR address constants, cause code constants, MSTATUS bit indices (MIE=3, MPIE=7), state enum, csr_load bit positions.
- Sub-module csr_trap_prio: combinational priority encoder producing trap_req and cause.

Test Plan:
- mstatus_q=0x8, irq_ext=1, trap_pc=0x100, mtvec_q=0x400 -> flush for 2 cycles; MEPC←0x100, MCAUSE←0x8000000B, MSTATUS←0x80; redirect to 0x400 at T+6.
- ecall and irq_timer together, mstatus_q=0x8 -> MCAUSE←11, ecall wins.
- irq_timer=1 with mstatus_q=0x0 -> no trap, busy stays 0, sw_csr_ready=1.
- mret with mstatus_q=0x80, mepc_q=0x104 -> MSTATUS←0x88; redirect to 0x104 at T+4.
- sw_csr_we to 0x305 during DRAIN -> ready=0; granted in the first IDLE cycle with csr_load=0010. Write to 0x7C0 -> ready=1, csr_load=0.
- rst asserted in SAVE_CAUSE -> all outputs 0 asynchronously, IDLE after release. With VECTORED_TRAP_EN, mtvec_q=0x401, timer irq -> redirect to 0x41C.
